// File: rtl/mvau_weight_loader.sv
// Streams IN_W-bit weight chunks from an AXI-Stream slave, packs BEATS chunks per
// SIMD*TW-bit word and writes WMEM_DEPTH consecutive words into the weight memory.
module mvau_weight_loader #(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4,
    parameter int IN_W         = 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    input  logic [IN_W-1:0]         s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic                    wmem_we,
    output logic [WMEM_ADDR_BW-1:0] wmem_waddr,
    output logic [SIMD*TW-1:0]      wmem_wdata
);

    localparam int WORD_W = SIMD * TW;
    localparam int BEATS  = WORD_W / IN_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [WMEM_ADDR_BW-1:0] addr_q, addr_d;
    logic [WORD_W-1:0]       pack_q, pack_d;
    logic                    err_q, err_d;
    logic                    we_q, we_d;
    logic [WMEM_ADDR_BW-1:0] waddr_q, waddr_d;
    logic [WORD_W-1:0]       wdata_q, wdata_d;

    logic              accept;
    logic [WORD_W-1:0] word_v;

    assign accept = (state_q == S_LOAD) && s_axis_tvalid;

    // Pack register with the current chunk merged in; the full word on the last beat.
    always_comb begin
        word_v = pack_q;
        word_v[int'(beat_q) * IN_W +: IN_W] = s_axis_tdata;
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        pack_d  = pack_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    beat_d  = '0;
                    addr_d  = '0;
                    pack_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (beat_q == LAST_BEAT) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = word_v;
                        beat_d  = '0;
                        pack_d  = '0;
                        if (addr_q == LAST_ADDR) begin
                            // Final word: always written; tlast is expected exactly here.
                            state_d = S_DONE;
                            if (!s_axis_tlast) err_d = 1'b1;
                        end else begin
                            addr_d = addr_q + 1'b1;
                            if (s_axis_tlast) begin
                                err_d   = 1'b1;
                                state_d = S_DONE;
                            end
                        end
                    end else if (s_axis_tlast) begin
                        // Early end mid-word: drop the partial word.
                        err_d   = 1'b1;
                        state_d = S_DONE;
                        beat_d  = '0;
                        pack_d  = '0;
                    end else begin
                        pack_d = word_v;
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: only the loader's own registers are reset; the weight memory behind the
    // write port is never touched by reset, so loaded weights survive it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            pack_q  <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            pack_q  <= pack_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy          = (state_q == S_LOAD);
    assign done          = (state_q == S_DONE);
    assign s_axis_tready = (state_q == S_LOAD);
    assign err           = err_q;
    assign wmem_we       = we_q;
    assign wmem_waddr    = waddr_q;
    assign wmem_wdata    = wdata_q;

endmodule

// File: doc/mvau_weight_loader.md
MVAU_WEIGHT_LOADER -- requirements
Module: mvau_weight_loader

Interface
REQ-001 Parameter SIMD, default 2: number of weights per memory word.
REQ-002 Parameter TW, default 1: weight bit width.
REQ-003 Parameter WMEM_DEPTH, default 4: number of weight memory words to load.
REQ-004 Parameter WMEM_ADDR_BW, default 4: memory address width; satisfies 2^WMEM_ADDR_BW >= WMEM_DEPTH.
REQ-005 Parameter IN_W, default 1: input stream data width.
 - SIMD*TW SHALL be an integer multiple of IN_W.
 - BEATS = SIMD*TW/IN_W.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low (aclk, aresetn).
 - aclk  in  1  main clock, all logic on rising edge.
 - aresetn  in  1  asynchronous active-low reset.
REQ-007 Control ports:
 - start  in  1  single-cycle load request.
 - busy  out  1  high in LOAD.
 - done  out  1  high in DONE.
 - err  out  1  sticky framing error.
REQ-008 Input stream ports:
 - s_axis_tdata  in  IN_W  weight chunk.
 - s_axis_tvalid  in  1  chunk valid.
 - s_axis_tready  out  1  loader ready.
 - s_axis_tlast  in  1  marks the final chunk of the whole load.
REQ-009 Memory write port (the write side of the SIMD*TW-wide weight memory):
 - wmem_we  out  1  write enable.
 - wmem_waddr  out  WMEM_ADDR_BW  write address.
 - wmem_wdata  out  SIMD*TW  write word.

Function
REQ-010 The loader SHALL implement states IDLE, LOAD and DONE; the reset state is IDLE.
REQ-011 Transitions:
 - IDLE -> LOAD on start=1, clearing the beat counter, address counter and err.
 - DONE -> LOAD on start=1, with the same clearing.
 - start in LOAD SHALL be ignored.
REQ-012 s_axis_tready SHALL be 1 only in LOAD. It is a registered state decode and SHALL NOT depend combinationally on s_axis_tvalid.
REQ-013 A beat is accepted when s_axis_tvalid=1 and s_axis_tready=1 at a rising edge; no other cycle alters the pack register or counters.
REQ-014 Packing: accepted beat k (0..BEATS-1) within a word SHALL be placed at wmem_wdata bits [k*IN_W +: IN_W] (first beat in the LSBs).
REQ-015 Write timing: in the cycle after acceptance of beat BEATS-1, the loader SHALL assert wmem_we=1 for exactly one cycle.
 - wmem_wdata carries the packed word.
 - wmem_waddr carries the current word index (0 for the first word, incrementing by 1 per word).
 - Latency from final-beat acceptance to write SHALL be exactly 1 cycle.
REQ-016 Accepting beats for the next word in the write cycle SHALL be allowed; full throughput is one beat per cycle with no bubbles.
REQ-017 wmem_waddr, wmem_wdata and wmem_we SHALL be registered outputs.
 - wmem_waddr and wmem_wdata hold their last values when wmem_we=0.
REQ-018 After the write of address WMEM_DEPTH-1 is issued, the state SHALL become DONE in that same cycle.
 - s_axis_tready is therefore 0 from that cycle onward.
 - The address SHALL never exceed WMEM_DEPTH-1 and SHALL NOT wrap.
REQ-019 Early tlast: if s_axis_tlast=1 on any accepted beat other than the final beat of word WMEM_DEPTH-1:
 - err SHALL be set.
 - The partial word SHALL be discarded (no write).
 - The state SHALL go to DONE on the next cycle.
 - Complete words already written remain valid.
REQ-020 Missing tlast: if s_axis_tlast=0 on the final beat of word WMEM_DEPTH-1, the final write SHALL still occur, the state SHALL go to DONE, and err SHALL be set.
REQ-021 err SHALL remain set until the next accepted start or reset.
REQ-022 done SHALL stay high in DONE until start is accepted.
REQ-023 busy and done SHALL never both be 1.

Reset
REQ-024 While aresetn=0, asynchronously, the loader SHALL force:
 - state=IDLE.
 - busy=0, done=0, err=0.
 - s_axis_tready=0, wmem_we=0.
 - wmem_waddr=0, wmem_wdata=0.
 - Beat counter and pack register cleared.
REQ-025 Reset asserted mid-LOAD SHALL abort the load with no further write; after release, the loader SHALL wait in IDLE for start.
REQ-026 Memory contents SHALL NOT be modified by reset.

Verification (SIMD=2, TW=4, IN_W=4, WMEM_DEPTH=4, WMEM_ADDR_BW=2, BEATS=2)
REQ-027 Nominal load: start, then beats 0x1,0x2,0x3,0x4,0x5,0x6,0x7,0x8 with tlast on the last beat and tvalid held high.
 - Writes: addr0=0x21, addr1=0x43, addr2=0x65, addr3=0x87, each 1 cycle after its second beat.
 - Then done=1, err=0, s_axis_tready=0.
REQ-028 Backpressure gaps: same data with tvalid toggled 1/0 every cycle.
 - Writes are identical to REQ-027.
 - No write occurs without a completed word.
REQ-029 Early tlast: tlast on beat 3 (first beat of word 1).
 - Only addr0=0x21 is written.
 - err=1 and done=1 one cycle after that beat.
REQ-030 Missing tlast: 8 beats, no tlast.
 - All 4 words are written.
 - done=1, err=1.
 - A following start clears err and restarts at addr0.
REQ-031 Reset mid-load: drop aresetn after beat 5.
 - Outputs go to reset values immediately.
 - No write of addr2 occurs.
 - After release, tready=0 until start.
REQ-032 Start ignored in LOAD: a start pulse during beat 4 SHALL NOT reset the address; the writes still match REQ-027.
